// File: rtl/energy_term_sequencer.sv
// Fetches one coupling row per step and streams the signed local-energy term
// t_i = s_i * sum_{j!=i} s_j*J_ij to the energy accumulator, with clear and done framing.
module energy_term_sequencer #(
  parameter int NUM_SPIN     = 16,
  parameter int WEIGHT_WIDTH = 4,
  parameter int OUT_WIDTH    = 16,
  localparam int ROW_W       = $clog2(NUM_SPIN)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             en_i,
  input  logic                             start_i,
  input  logic [NUM_SPIN-1:0]              spin_i,
  output logic                             weight_req_o,
  output logic [ROW_W-1:0]                 weight_addr_o,
  input  logic                             weight_valid_i,
  input  logic [NUM_SPIN*WEIGHT_WIDTH-1:0] weight_i,
  output logic                             clear_o,
  output logic                             valid_o,
  output logic [OUT_WIDTH-1:0]             data_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [2:0]                       state_o
);

  if (NUM_SPIN < 2 || OUT_WIDTH < WEIGHT_WIDTH + ROW_W + 1) begin : g_bad_params
    $error("energy_term_sequencer: NUM_SPIN must be >= 2 and OUT_WIDTH >= WEIGHT_WIDTH+clog2(NUM_SPIN)+1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    REQ   = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Handshake: a row transfers in the cycle weight_req_o & weight_valid_i, which
  // can only be true in REQ with en_i high; weight_valid_i is ignored otherwise.
  state_t                             state_q, state_n;
  logic [ROW_W-1:0]                   row_q, row_n;
  logic [NUM_SPIN-1:0]                spin_q, spin_n;
  logic [NUM_SPIN*WEIGHT_WIDTH-1:0]   wrow_q, wrow_n;
  logic [OUT_WIDTH-1:0]               data_q, data_n;
  logic                               clear_q, clear_n;
  logic                               valid_q, valid_n;
  logic                               done_q, done_n;
  logic [OUT_WIDTH-1:0]               ext_c, sum_c, term_c;

  // Two's-complement arithmetic at OUT_WIDTH is exact because the width check
  // above leaves room for (N-1) weights of full magnitude.
  always_comb begin
    sum_c = '0;
    ext_c = '0;
    for (int j = 0; j < NUM_SPIN; j++) begin
      ext_c = {{(OUT_WIDTH-WEIGHT_WIDTH){wrow_q[j*WEIGHT_WIDTH+WEIGHT_WIDTH-1]}},
               wrow_q[j*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
      if (ROW_W'(j) != row_q) begin
        sum_c = spin_q[j] ? (sum_c + ext_c) : (sum_c - ext_c);
      end
    end
    term_c = spin_q[row_q] ? sum_c : (~sum_c + OUT_WIDTH'(1));
  end

  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    spin_n  = spin_q;
    wrow_n  = wrow_q;
    data_n  = data_q;
    clear_n = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          spin_n  = spin_i;
          row_n   = '0;
          clear_n = 1'b1;
          state_n = CLEAR;
        end
      end
      CLEAR: state_n = REQ;
      REQ: begin
        if (weight_valid_i) begin
          wrow_n  = weight_i;
          state_n = CALC;
        end
      end
      CALC: begin
        data_n  = term_c;
        valid_n = 1'b1;
        if (row_q == ROW_W'(NUM_SPIN-1)) begin
          state_n = DONE;
        end else begin
          row_n   = row_q + ROW_W'(1);
          state_n = REQ;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // With en_i low every register, including pending pulse flags, holds its value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      row_q   <= '0;
      spin_q  <= '0;
      wrow_q  <= '0;
      data_q  <= '0;
      clear_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (en_i) begin
      state_q <= state_n;
      row_q   <= row_n;
      spin_q  <= spin_n;
      wrow_q  <= wrow_n;
      data_q  <= data_n;
      clear_q <= clear_n;
      valid_q <= valid_n;
      done_q  <= done_n;
    end
  end

  assign weight_req_o  = (state_q == REQ) & en_i;
  assign weight_addr_o = row_q;
  assign clear_o       = clear_q & en_i;
  assign valid_o       = valid_q & en_i;
  assign done_o        = done_q & en_i;
  assign data_o        = data_q;
  assign busy_o        = (state_q != IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_energy_term_sequencer.sv
// Directed bench for energy_term_sequencer (N=4, W=4): expected terms are queued at
// start and popped by a monitor whenever valid_o is seen.
module tb_energy_term_sequencer;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int OW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            en, start, weight_valid;
  logic [N-1:0]    spin;
  logic [N*W-1:0]  weight;
  logic            weight_req, clear, valid, busy, done;
  logic [1:0]      weight_addr;
  logic [OW-1:0]   data;
  logic [2:0]      state_dbg;

  logic [N*W-1:0]  mem [N];
  assign weight = mem[weight_addr];

  energy_term_sequencer #(.NUM_SPIN(N), .WEIGHT_WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .start_i(start), .spin_i(spin),
    .weight_req_o(weight_req), .weight_addr_o(weight_addr),
    .weight_valid_i(weight_valid), .weight_i(weight),
    .clear_o(clear), .valid_o(valid), .data_o(data), .busy_o(busy),
    .done_o(done), .state_o(state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int            vcyc_q[$];
  int            acc, clear_cyc, done_cyc, busy_rise, busy_fall;
  logic          prev_valid = 1'b0;
  logic          prev_busy  = 1'b0;

  always @(negedge clk) begin
    if (valid) begin
      chk("no_back_to_back_valid", {31'd0, prev_valid}, 32'd0);
      chk("term_pending", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) chk("term", {16'd0, data}, {16'd0, exp_q.pop_front()});
      vcyc_q.push_back(cyc);
      acc += int'($signed(data));
    end
    if (clear) begin
      clear_cyc = cyc;
      acc = 0;
    end
    if (done) done_cyc = cyc;
    if (busy && !prev_busy) busy_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    prev_valid = valid;
    prev_busy  = busy;
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [W-1:0] diag, input logic [W-1:0] off, input bit per_row);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mem[i][j*W +: W] = (i == j) ? diag : (per_row ? W'(i + 1) : off);
  endtask

  int s;
  task automatic start_eval(input logic [N-1:0] sp, input logic [OW-1:0] t0,
                            input logic [OW-1:0] t1, input logic [OW-1:0] t2,
                            input logic [OW-1:0] t3);
    exp_q.push_back(t0); exp_q.push_back(t1);
    exp_q.push_back(t2); exp_q.push_back(t3);
    vcyc_q.delete();
    start = 1'b1;
    spin  = sp;
    s     = cyc;
    tick();
    start = 1'b0;
    spin  = ~sp;
  endtask

  task automatic finish_eval(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
    tick();
    chk({name, "_queue_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_req"},   {31'd0, weight_req}, 32'd0);
    chk({name, "_addr"},  {30'd0, weight_addr}, 32'd0);
    chk({name, "_clear"}, {31'd0, clear}, 32'd0);
    chk({name, "_valid"}, {31'd0, valid}, 32'd0);
    chk({name, "_data"},  {16'd0, data}, 32'd0);
    chk({name, "_busy"},  {31'd0, busy}, 32'd0);
    chk({name, "_done"},  {31'd0, done}, 32'd0);
    chk({name, "_state"}, {29'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; spin = '0; weight_valid = 1'b1;
    fill(4'd0, 4'd1, 1'b0);
    tick(); tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // all-positive spins, unit couplings: exact cycle timing
    start_eval(4'b1111, 16'd3, 16'd3, 16'd3, 16'd3);
    finish_eval("allpos");
    chk("allpos_clear_cyc", clear_cyc - s, 32'd1);
    for (int k = 0; k < N; k++) chk("allpos_valid_cyc", vcyc_q[k] - s, 4 + 2 * k);
    chk("allpos_valid_count", vcyc_q.size(), 32'd4);
    chk("allpos_done_cyc", done_cyc - s, 32'd11);
    chk("allpos_busy_rise", busy_rise - s, 32'd1);
    chk("allpos_busy_fall", busy_fall - s, 32'd11);
    chk("allpos_acc", acc, 32'd12);

    // alternating spins
    start_eval(4'b0101, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    finish_eval("alt");
    chk("alt_acc", acc, -32'sd4);

    // diagonal masked out
    fill(4'd7, 4'd0, 1'b0);
    start_eval(4'b1011, 16'd0, 16'd0, 16'd0, 16'd0);
    finish_eval("diag");

    // most negative off-diagonal weight
    fill(4'd0, 4'b1000, 1'b0);
    start_eval(4'b1111, 16'hFFE8, 16'hFFE8, 16'hFFE8, 16'hFFE8);
    finish_eval("neg8");
    chk("neg8_acc", acc, -32'sd96);

    // memory wait states on row 1 (row i off-diagonal J = i+1)
    fill(4'd0, 4'd0, 1'b1);
    start_eval(4'b1111, 16'd3, 16'd6, 16'd9, 16'd12);
    tick(); tick(); tick();
    weight_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) weight_valid = 1'b1;
      @(negedge clk);
      chk("wait_req_held", {31'd0, weight_req}, 32'd1);
      chk("wait_addr_held", {30'd0, weight_addr}, 32'd1);
      if (k > 0) chk("wait_no_valid", {31'd0, valid}, 32'd0);
      tick();
    end
    finish_eval("wait");
    chk("wait_row1_valid_cyc", vcyc_q[1] - s, 32'd9);
    chk("wait_done_cyc", done_cyc - s, 32'd14);

    // enable freeze over a pending term, plus a start while busy
    fill(4'd0, 4'd1, 1'b0);
    start_eval(4'b1111, 16'd3, 16'd3, 16'd3, 16'd3);
    tick();
    start = 1'b1;
    spin  = 4'b0000;
    tick();
    start = 1'b0;
    tick();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("freeze_valid_low", {31'd0, valid}, 32'd0);
      chk("freeze_req_low", {31'd0, weight_req}, 32'd0);
      tick();
    end
    en = 1'b1;
    finish_eval("freeze");
    chk("freeze_first_valid_cyc", vcyc_q[0] - s, 32'd9);
    chk("freeze_valid_count", vcyc_q.size(), 32'd4);

    // asynchronous reset during row 2, then a clean rerun
    fill(4'd0, 4'd0, 1'b1);
    start_eval(4'b1111, 16'd3, 16'd6, 16'd9, 16'd12);
    for (int k = 0; k < 6; k++) tick();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrun_reset");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    start_eval(4'b1111, 16'd3, 16'd6, 16'd9, 16'd12);
    finish_eval("rerun");
    chk("rerun_clear_cyc", clear_cyc - s, 32'd1);
    chk("rerun_valid_count", vcyc_q.size(), 32'd4);
    chk("rerun_acc", acc, 32'd30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
